// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - Shared constants and types for the instruction fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int FETCH_DEPTH = 2;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [$clog2(FETCH_DEPTH):0] fetch_ptr_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - Ring of in-flight fetches with separate alloc, fill and read pointers.
// FETCH_BYPASS_EN: a word filling the head entry is forwarded to the head output the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc,
  input  logic [XLEN-1:0]        alloc_pc,
  input  logic                   fill,
  input  logic [XLEN-1:0]        fill_instr,
  input  logic                   rd,
  output logic                   head_valid,
  output logic [XLEN-1:0]        head_instr,
  output logic [XLEN-1:0]        head_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] pending
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0] ptr_t;

  fetch_entry_t entries [DEPTH];
  fetch_entry_t head;
  ptr_t         alloc_ptr;
  ptr_t         fill_ptr;
  ptr_t         rd_ptr;

  assign count   = alloc_ptr - rd_ptr;
  assign pending = alloc_ptr - fill_ptr;
  assign head    = entries[rd_ptr[PW-1:0]];
  assign head_pc = head.pc;

  always_comb begin
    head_valid = head.filled && (count != '0);
    head_instr = head.instr;
`ifdef FETCH_BYPASS_EN
    if (fill && (fill_ptr == rd_ptr) && (count != '0)) begin
      head_valid = 1'b1;
      head_instr = fill_instr;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
      end
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].filled <= 1'b0;
      end
    end else begin
      if (alloc) begin
        entries[alloc_ptr[PW-1:0]] <= '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
        alloc_ptr <= alloc_ptr + ptr_t'(1);
      end
      if (fill) begin
        entries[fill_ptr[PW-1:0]].instr  <= fill_instr;
        entries[fill_ptr[PW-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + ptr_t'(1);
      end
      // Clearing filled on read keeps a wrapped slot from looking valid; with bypass this
      // also overrides a same-cycle fill of the entry being consumed.
      if (rd) begin
        entries[rd_ptr[PW-1:0]].filled <= 1'b0;
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch: PC, imem request issue, stale-response drop and decode handoff.
// FETCH_BYPASS_EN: zero-cycle response-to-decode forwarding through the queue head.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = FETCH_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   pending;
  logic [CW:0]     outstanding;
  logic            grant;
  logic            fill;
  logic            rd;
  logic            head_valid;
  logic [XLEN-1:0] head_instr;
  logic [XLEN-1:0] head_pc;

  // Stale responses still occupy imem slots, so they count against the request cap.
  assign outstanding = {1'b0, count} + {1'b0, drop_cnt};
  assign imem_req    = !rst && !redirect_valid && (outstanding < DEPTH_W);
  assign imem_addr   = pc_q & ~32'h3;
  assign grant       = imem_req && imem_gnt;
  assign fill        = imem_rvalid && (drop_cnt == '0);
  assign rd          = id_valid && id_ready;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .alloc      (grant),
    .alloc_pc   (imem_addr),
    .fill       (fill),
    .fill_instr (imem_rdata),
    .rd         (rd),
    .head_valid (head_valid),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count),
    .pending    (pending)
  );

  assign id_valid = head_valid && !redirect_valid;
  assign id_instr = id_valid ? head_instr : NOP_INSTR;
  assign id_pc    = head_pc;
  assign id_pc4   = head_pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ~32'h3;
    end else if (grant) begin
      pc_q <= pc_q + XLEN'(4);
    end
  end

  // On redirect every unfilled request becomes stale; a response arriving that same cycle
  // retires one of them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= drop_cnt + pending - CW'(imem_rvalid);
    end else if (imem_rvalid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Scoreboard bench for fetch_unit: directed fetch, stall, redirect, reset and wrap.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_HS = 1;
`else
  localparam int FIRST_HS = 2;
`endif

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  resp_t       resp_q[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          gnt_budget = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rand_gnt = 1'b0;
  int          first_hs = -1;
  logic        obs_valid;
  logic        obs_rvalid;
  logic        obs_req;
  logic [31:0] mon_exp;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock: imem model presents the next due response, grants within budget, logs grants.
  task automatic step();
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(resp_q[0].addr);
      void'(resp_q.pop_front());
    end
    imem_gnt = (gnt_budget > 0) && (!rand_gnt || ($urandom_range(0, 1) == 1));
    #1;
    obs_valid  = id_valid;
    obs_rvalid = imem_rvalid;
    obs_req    = imem_req;
    if (imem_req && imem_gnt) begin
      resp_q.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
      gnt_budget--;
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    cyc++;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_rdy, input string tag);
    int n;
    n = 0;
    while ((gnt_budget > 0 || resp_q.size() > 0 || exp_q.size() > 0) && n < 400) begin
      id_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    id_ready = 1'b1;
    step();
    step();
    chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_id_instr"}, id_instr, NOP);
    chk({tag, "_id_pc"}, id_pc, 32'h0);
    chk({tag, "_id_pc4"}, id_pc4, 32'h4);
  endtask

  // Monitor: pops the scoreboard on every decode handshake.
  always @(negedge clk) begin
    #2;
    if (!rst && id_valid && id_ready) begin
      if (first_hs < 0) first_hs = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output id_pc=%h required=none", id_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("id_pc", id_pc, mon_exp);
        chk("id_pc4", id_pc4, mon_exp + 32'd4);
        chk("id_instr", id_instr, instr_of(mon_exp));
      end
    end
  end

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    cyc = 0;

    // T1: straight-line fetch, 1-cycle memory
    gnt_budget = 3;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    drain(1'b0, "t1");
    chk("t1_first_valid_cycle", 32'(first_hs), 32'(FIRST_HS));

    // T2: decode stall fills the queue and blocks requests
    id_ready = 1'b0;
    gnt_budget = 3;
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 2) begin
        chk("t2_req_low", 32'(imem_req), 32'd0);
        chk("t2_hold_valid", 32'(id_valid), 32'd1);
        chk("t2_hold_pc", id_pc, 32'hC);
        chk("t2_hold_instr", id_instr, instr_of(32'hC));
      end
    end
    drain(1'b0, "t2");

    // T3: redirect with two requests in flight
    redirect_to(32'h10);
    lat_min = 3;
    lat_max = 3;
    gnt_budget = 4;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    step();
    step();
    chk("t3_inflight", 32'(resp_q.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_drop2", 32'(dut.drop_cnt), 32'd2);
    drain(1'b0, "t3");
    chk("t3_drop0", 32'(dut.drop_cnt), 32'd0);

    // T4: redirect coincides with a would-be handshake and a response
    lat_min = 1;
    lat_max = 1;
    redirect_to(32'h200);
    id_ready = 1'b0;
    gnt_budget = 4;
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h304);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    id_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("t4_rvalid_seen", 32'(obs_rvalid), 32'd1);
    chk("t4_valid_masked", 32'(obs_valid), 32'd0);
    chk("t4_req_masked", 32'(obs_req), 32'd0);
    chk("t4_drop", 32'(dut.drop_cnt), 32'd0);
    chk("t4_addr", imem_addr, 32'h300);
    drain(1'b0, "t4");

    // T5: reset with a full queue and a response pending
    lat_min = 3;
    lat_max = 3;
    id_ready = 1'b0;
    gnt_budget = 2;
    repeat (4) step();
    chk("t5_full_valid", 32'(id_valid), 32'd1);
    chk("t5_full_req", 32'(imem_req), 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5");
    resp_q.delete();
    exp_q.delete();
    gnt_budget = 0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("t5_restart_addr", imem_addr, 32'h0);
    chk("t5_restart_req", 32'(imem_req), 32'd1);
    id_ready = 1'b1;
    lat_min = 1;
    lat_max = 1;
    gnt_budget = 2;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    drain(1'b0, "t5");

    // T6: random grant/latency/stall across the 32-bit PC wrap
    lat_min = 1;
    lat_max = 4;
    rand_gnt = 1'b1;
    redirect_to(32'hFFFF_FFF0);
    gnt_budget = 6;
    exp_q.push_back(32'hFFFF_FFF0);
    exp_q.push_back(32'hFFFF_FFF4);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    drain(1'b1, "t6");
    chk("t6_drop0", 32'(dut.drop_cnt), 32'd0);
    chk("t6_next_addr", imem_addr, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
